// File: rtl/patternbuf_pkg.sv
// Shared definitions for the pattern-buffer loader: size defaults, FSM states
// and counter-width helper.
package patternbuf_pkg;

  localparam int unsigned DEF_BUFFER_SIZE  = 22;
  localparam int unsigned DEF_BUFFER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT,
    DONE
  } loader_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_BYTE_CNT_W = cnt_width(DEF_BUFFER_SIZE);
  localparam int unsigned DEF_BIT_CNT_W  = cnt_width(DEF_BUFFER_WIDTH);

endpackage

// File: rtl/patternbuf_serdes.sv
// Byte serialiser for the pattern buffer shift port: MSB-first out on sin,
// LSB-in capture of sout, one ssel cycle per bit.
module patternbuf_serdes
  import patternbuf_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_BUFFER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] byte_in,
  input  logic             sout,
  output logic             sin,
  output logic             ssel,
  output logic [WIDTH-1:0] rx_byte,
  output logic             done
);

  localparam int unsigned BIT_CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0]     tx;
  logic [BIT_CNT_W-1:0] bit_cnt;

  assign sin  = tx[WIDTH-1];
  // Strobe on the edge that completes the last bit of the byte.
  assign done = ssel && (bit_cnt == BIT_CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx      <= '0;
      rx_byte <= '0;
      bit_cnt <= '0;
      ssel    <= 1'b0;
    end else if (abort) begin
      ssel <= 1'b0;
    end else if (start) begin
      tx      <= byte_in;
      bit_cnt <= '0;
      ssel    <= 1'b1;
    end else if (ssel) begin
      tx      <= tx << 1;
      rx_byte <= {rx_byte[WIDTH-2:0], sout};
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      if (done) begin
        ssel <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/patternbuf_loader.sv
// Sequences full-buffer loads over the serial shift port and arbitrates the
// buffer against PAT's parallel field-write port.
module patternbuf_loader
  import patternbuf_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE  = DEF_BUFFER_SIZE,
  parameter int unsigned BUFFER_WIDTH = DEF_BUFFER_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    load_abort,
  input  logic [BUFFER_WIDTH-1:0] load_data,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [BUFFER_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    load_done,
  output logic                    busy,
  input  logic                    pat_write_req,
  input  logic [BUFFER_SIZE-1:0]  pat_wp,
  input  logic [BUFFER_WIDTH-1:0] pat_data,
  output logic                    pat_stall,
  output logic                    buf_ssel,
  output logic                    buf_sin,
  input  logic                    buf_sout,
  output logic                    buf_field_write,
  output logic [BUFFER_SIZE-1:0]  buf_fieldwp,
  output logic [BUFFER_WIDTH-1:0] buf_field_in
);

  localparam int unsigned BYTE_CNT_W = cnt_width(BUFFER_SIZE);

  loader_state_t           state;
  logic [BYTE_CNT_W-1:0]   byte_cnt;
  logic                    abort_req;
  logic                    serdes_start;
  logic                    shift_last;
  logic [BUFFER_WIDTH-1:0] rx_byte;

  assign abort_req    = load_abort && (state != IDLE);
  assign serdes_start = (state == WAIT_BYTE) && load_valid && !load_abort;

  // Field writes only reach the buffer while the shift port is idle.
  assign busy            = (state != IDLE);
  assign buf_field_write = pat_write_req && (state == IDLE);
  assign pat_stall       = pat_write_req && busy;
  assign buf_fieldwp     = pat_wp;
  assign buf_field_in    = pat_data;
  assign rd_data         = rx_byte;

  patternbuf_serdes #(
    .WIDTH(BUFFER_WIDTH)
  ) u_serdes (
    .clk    (clk),
    .reset  (reset),
    .start  (serdes_start),
    .abort  (abort_req),
    .byte_in(load_data),
    .sout   (buf_sout),
    .sin    (buf_sin),
    .ssel   (buf_ssel),
    .rx_byte(rx_byte),
    .done   (shift_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      load_ready <= 1'b0;
      rd_valid   <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      rd_valid  <= 1'b0;
      load_done <= 1'b0;
      if (abort_req) begin
        state      <= IDLE;
        load_ready <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (load_start) begin
              state      <= WAIT_BYTE;
              byte_cnt   <= '0;
              load_ready <= 1'b1;
            end
          end
          WAIT_BYTE: begin
            if (load_valid) begin
              state      <= SHIFT;
              load_ready <= 1'b0;
            end
          end
          SHIFT: begin
            if (shift_last) begin
              rd_valid <= 1'b1;
              byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
              if (byte_cnt == BYTE_CNT_W'(BUFFER_SIZE - 1)) begin
                state     <= DONE;
                load_done <= 1'b1;
              end else begin
                state      <= WAIT_BYTE;
                load_ready <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_patternbuf_loader.sv
// Scoreboard bench for patternbuf_loader driving a serial/parallel pattern
// buffer model wired to the buf_* port.
module tb_patternbuf_loader;
  import patternbuf_pkg::*;

  localparam int unsigned SIZE  = DEF_BUFFER_SIZE;
  localparam int unsigned W     = DEF_BUFFER_WIDTH;
  localparam int unsigned NBITS = SIZE * W;

  logic            clk = 1'b0;
  logic            reset;
  logic            load_start, load_abort, load_valid, load_ready;
  logic [W-1:0]    load_data, rd_data, pat_data, buf_field_in;
  logic            rd_valid, load_done, busy;
  logic            pat_write_req, pat_stall;
  logic [SIZE-1:0] pat_wp, buf_fieldwp;
  logic            buf_ssel, buf_sin, buf_sout, buf_field_write;

  always #5 clk = ~clk;

  patternbuf_loader #(
    .BUFFER_SIZE (SIZE),
    .BUFFER_WIDTH(W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .load_abort     (load_abort),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .load_done      (load_done),
    .busy           (busy),
    .pat_write_req  (pat_write_req),
    .pat_wp         (pat_wp),
    .pat_data       (pat_data),
    .pat_stall      (pat_stall),
    .buf_ssel       (buf_ssel),
    .buf_sin        (buf_sin),
    .buf_sout       (buf_sout),
    .buf_field_write(buf_field_write),
    .buf_fieldwp    (buf_fieldwp),
    .buf_field_in   (buf_field_in)
  );

  // Buffer model: pattern[i] = flat[i*W +: W]; shifts in at pattern[0] LSB,
  // shifts out of pattern[SIZE-1] MSB.
  logic [NBITS-1:0] flat = '0;
  logic [NBITS-1:0] preload_vec = '0;
  logic             preload_go = 1'b0;
  assign buf_sout = flat[NBITS-1];

  always @(posedge clk) begin
    if (preload_go) flat <= preload_vec;
    else if (buf_ssel) flat <= {flat[NBITS-2:0], buf_sin};
    else if (buf_field_write) begin
      for (int i = 0; i < SIZE; i++)
        if (buf_fieldwp[i]) flat[i*W +: W] <= buf_field_in;
    end
  end

  int n_chk = 0, n_fail = 0;
  int n_rd = 0, n_done = 0, n_shift = 0, ncyc = 0, hs_cyc = 0, done_gap = 0;
  bit hs_pending = 1'b0;
  bit exp_busy = 1'b0;
  logic [W-1:0] rd_exp[$];
  logic [W-1:0] exp_pat[SIZE];
  logic [W-1:0] tx_bytes[SIZE];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on rd_valid plus per-cycle arbitration checks.
  always @(negedge clk) begin
    ncyc++;
    if (reset) begin
      exp_busy = 1'b0;
    end else begin
      check("excl_ssel_fw", 32'(buf_ssel & buf_field_write), 32'(0));
      check("busy", 32'(busy), 32'(exp_busy));
      if (pat_write_req) begin
        check("pat_stall", 32'(pat_stall), 32'(exp_busy));
        check("field_write", 32'(buf_field_write), 32'(!exp_busy));
      end
      if (buf_ssel) n_shift++;
      if (hs_pending && load_valid && load_ready) begin
        hs_cyc = ncyc;
        hs_pending = 1'b0;
      end
      if (rd_valid) begin
        n_rd++;
        if (rd_exp.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_unexpected: got rd_valid with rd_data %0h, required none", rd_data);
        end else begin
          check("rd_data", 32'(rd_data), 32'(rd_exp.pop_front()));
        end
      end
      if (load_done) begin
        n_done++;
        done_gap = ncyc - hs_cyc;
        check("done_with_rd_valid", 32'(rd_valid), 32'(1));
      end
      if (load_done || (load_abort && exp_busy)) exp_busy = 1'b0;
      else if (load_start && !exp_busy) exp_busy = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [W-1:0] base);
    for (int i = 0; i < SIZE; i++) begin
      exp_pat[i] = base + W'(i);
      preload_vec[i*W +: W] = base + W'(i);
    end
    preload_go = 1'b1;
    tick();
    preload_go = 1'b0;
  endtask

  task automatic check_contents();
    for (int i = 0; i < SIZE; i++)
      check($sformatf("pattern[%0d]", i), 32'(flat[i*W +: W]), 32'(exp_pat[i]));
  endtask

  task automatic send_byte(input logic [W-1:0] b, input int unsigned gap);
    int unsigned n = 0;
    while (load_ready !== 1'b1 && n < 40) begin tick(); n++; end
    check("ready_wait", 32'(load_ready), 32'(1));
    for (int unsigned g = 0; g < gap; g++) begin
      tick();
      check("ready_held", 32'(load_ready), 32'(1));
    end
    load_data  = b;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_load(input int unsigned gap);
    int before_done = n_done;
    int before_rd   = n_rd;
    int before_sh   = n_shift;
    int n = 0;
    hs_pending = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < SIZE; k++) begin
      rd_exp.push_back(exp_pat[SIZE-1-k]);
      send_byte(tx_bytes[k], (k == 0) ? 0 : gap);
    end
    for (int k = 0; k < SIZE; k++) exp_pat[SIZE-1-k] = tx_bytes[k];
    while (n_done == before_done && n < 40) begin tick(); n++; end
    check("load_done_count", 32'(n_done - before_done), 32'(1));
    check("rd_valid_count", 32'(n_rd - before_rd), 32'(SIZE));
    check("shift_count", 32'(n_shift - before_sh), 32'(NBITS));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sh0, rd0, dn0;
    reset = 1'b1; load_start = 0; load_abort = 0; load_valid = 0; load_data = '0;
    pat_write_req = 0; pat_wp = '0; pat_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_load_ready", 32'(load_ready), 32'(0));
    check("rst_rd_valid", 32'(rd_valid), 32'(0));
    check("rst_load_done", 32'(load_done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ssel", 32'(buf_ssel), 32'(0));
    check("rst_sin", 32'(buf_sin), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));

    // Reset in the middle of a byte shift.
    load_start = 1'b1; tick(); load_start = 1'b0;
    send_byte(8'h5A, 0);
    tick(); tick();
    check("ssel_pre_reset", 32'(buf_ssel), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("reset_ssel_async", 32'(buf_ssel), 32'(0));
    check("reset_busy_async", 32'(busy), 32'(0));
    check("reset_rd_valid", 32'(rd_valid), 32'(0));
    tick(); tick();
    reset = 1'b0;
    sh0 = n_shift;
    tick(); tick();
    check("post_reset_busy", 32'(busy), 32'(0));
    check("post_reset_no_shift", 32'(n_shift - sh0), 32'(0));
    pat_write_req = 1'b1; pat_wp = '0; pat_wp[3] = 1'b1; pat_data = 8'h3C;
    #1 check("post_reset_fw", 32'(buf_field_write), 32'(1));
    tick();
    pat_write_req = 1'b0;
    check("post_reset_write", 32'(flat[3*W +: W]), 32'h3C);

    // Full load 0x15..0x00, back-to-back.
    preload(8'hC0);
    for (int k = 0; k < SIZE; k++) tx_bytes[k] = W'(SIZE - 1 - k);
    do_load(0);
    check("done_latency_1", 32'(done_gap), 32'(198));
    for (int i = 0; i < SIZE; i++)
      check($sformatf("load1_pattern[%0d]", i), 32'(flat[i*W +: W]), 32'(i));

    // Second load of 0xFF; readback must be 0x15..0x00.
    for (int k = 0; k < SIZE; k++) tx_bytes[k] = 8'hFF;
    do_load(0);
    check("done_latency_2", 32'(done_gap), 32'(198));
    check_contents();

    // PAT write held across a load: lands at load_start and again once idle.
    pat_write_req = 1'b1; pat_wp = '0; pat_wp[5] = 1'b1; pat_data = 8'hA5;
    exp_pat[5] = 8'hA5;
    for (int k = 0; k < SIZE; k++) tx_bytes[k] = 8'h40 + W'(k);
    do_load(0);
    tick();
    pat_write_req = 1'b0;
    exp_pat[5] = 8'hA5;
    check_contents();

    // Abort on shift cycle 3 of byte 4.
    preload(8'h80);
    rd0 = n_rd; dn0 = n_done; sh0 = n_shift;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_exp.push_back(exp_pat[SIZE-1-k]);
      send_byte(8'h60 + W'(k), 0);
    end
    send_byte(8'h64, 0);
    tick(); tick(); tick();
    check("ssel_before_abort", 32'(buf_ssel), 32'(1));
    load_abort = 1'b1; tick(); load_abort = 1'b0;
    check("abort_ssel", 32'(buf_ssel), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_ready", 32'(load_ready), 32'(0));
    repeat (12) tick();
    check("abort_rd_count", 32'(n_rd - rd0), 32'(4));
    check("abort_no_done", 32'(n_done - dn0), 32'(0));
    check("abort_shift_count", 32'(n_shift - sh0), 32'(36));
    check("abort_queue_empty", 32'(rd_exp.size()), 32'(0));

    // Host gaps of 5 cycles between bytes.
    preload(8'h10);
    for (int k = 0; k < SIZE; k++) tx_bytes[k] = W'(k * 13 + 7);
    do_load(5);
    check_contents();
    check("final_queue_empty", 32'(rd_exp.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/patternbuf_loader.md
Name: patternbuf_loader

Overview:
Controller that sequences the pattern buffer's serial-shift port and arbitrates it against PAT's parallel field-write port.
- Takes pattern bytes from the host over a valid/ready byte interface and serialises them MSB-first onto buf_sin/buf_ssel.
- Captures the displaced contents from buf_sout and returns them as readback bytes.
- Guarantees ssel and field_write are never asserted together.

Parameters:
BUFFER_SIZE, 22, number of pattern bytes in the buffer
BUFFER_WIDTH, 8, bits per pattern byte

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
load_start  in  1  begin a full-buffer load (sampled in IDLE only)
load_abort  in  1  abandon load, return to IDLE
load_data  in  BUFFER_WIDTH  host byte
load_valid  in  1  load_data valid
load_ready  out  1  loader accepts byte this cycle
rd_data  out  BUFFER_WIDTH  displaced byte shifted out of buffer
rd_valid  out  1  one-cycle pulse, rd_data valid
load_done  out  1  one-cycle pulse, full load complete
busy  out  1  state != IDLE
pat_write_req  in  1  PAT field write request
pat_wp  in  BUFFER_SIZE  PAT write pointer
pat_data  in  BUFFER_WIDTH  PAT write data
pat_stall  out  1  PAT write not accepted this cycle
buf_ssel  out  1  to buffer ssel
buf_sin  out  1  to buffer sin
buf_sout  in  1  from buffer sout
buf_field_write  out  1  to buffer field_write
buf_fieldwp  out  BUFFER_SIZE  to buffer fieldwp
buf_field_in  out  BUFFER_WIDTH  to buffer field_in

Behaviour:
- Reset (async): state IDLE; all outputs 0; byte_cnt, bit_cnt, shift registers 0.
- States: IDLE, WAIT_BYTE, SHIFT, DONE.
- IDLE:
  - load_start=1 -> WAIT_BYTE, byte_cnt=0.
  - load_start is accepted regardless of pat_write_req.
- WAIT_BYTE:
  - load_ready=1.
  - load_valid&load_ready -> latch load_data into tx register -> SHIFT, bit_cnt=0.
- SHIFT:
  - buf_ssel (registered) is high for exactly BUFFER_WIDTH consecutive cycles, starting the cycle after the handshake.
  - In the k-th shift cycle (k=0..W-1), buf_sin = tx[W-1-k].
  - buf_sout is sampled at every rising edge where buf_ssel=1, shifted into the rx register LSB-in.
  - After the W-th shift edge:
    - rd_data=rx, rd_valid=1 for one cycle; byte_cnt+1.
    - byte_cnt==BUFFER_SIZE-1 before increment -> DONE; else -> WAIT_BYTE.
- DONE: load_done=1 for one cycle (same cycle as the last rd_valid) -> IDLE.
- Byte order:
  - Host sends pattern[BUFFER_SIZE-1] first, down to pattern[0] last; after the load, pattern[i] holds the i-th-from-last byte sent.
  - Readback order: first rd_data = old pattern[BUFFER_SIZE-1], last = old pattern[0].
- Throughput: with load_valid held high, 1 handshake + W shift cycles = W+1 cycles per byte; a full load is BUFFER_SIZE*(W+1) cycles from the first handshake to load_done.
- Arbitration (combinational):
  - buf_field_write = pat_write_req & (state==IDLE).
  - pat_stall = pat_write_req & busy.
  - buf_fieldwp/buf_field_in pass through pat_wp/pat_data unconditionally.
  - A write coincident with load_start completes that cycle.
  - Stalled writes are not queued; PAT must hold its request.
- Exclusivity invariant: buf_ssel & buf_field_write never both 1.
- load_abort, any non-IDLE state:
  - Next state IDLE; buf_ssel=0 from the next edge.
  - No rd_valid/load_done pulse for the partial byte.
  - Buffer is left partially shifted (undefined content).
- load_start while busy: ignored.
- load_valid outside WAIT_BYTE: ignored, not consumed.
- Reset mid-shift: buf_ssel drops asynchronously; no further shifting.

Decomposition:
- Shared package patternbuf_pkg:
  - BUFFER_SIZE/BUFFER_WIDTH defaults.
  - Loader state enum.
  - Counter widths ($clog2 of size/width).
- One sub-module, patternbuf_serdes:
  - tx/rx shift registers and bit counter.
  - Inputs: start, byte; outputs: sin, ssel, rx byte, done pulse.
- The FSM and arbitration stay in patternbuf_loader.

Test Plan:
- Reset mid-SHIFT -> buf_ssel, busy, rd_valid 0 immediately; IDLE after release; subsequent PAT write passes (buf_field_write=1).
- Load 0x15..0x00 (22 bytes, back-to-back valid) into a buffer model -> pattern[i]==i; load_done exactly 198 cycles after the first handshake.
- Second load of 0xFF bytes after the above -> rd_data sequence 0x15,0x14,...,0x00; 22 rd_valid pulses; buffer all 0xFF.
- pat_write_req held (wp=5, data=0xA5) across a load -> pat_stall=1 and buf_field_write=0 for every busy cycle; write lands the first IDLE cycle; ssel/field_write never overlap (assertion).
- load_abort on shift cycle 3 of byte 4 -> buf_ssel low next cycle, no rd_valid for byte 4, no load_done, busy=0.
- Host gaps (load_valid low 5 cycles between bytes) -> load_ready held, no extra shifts, correct final contents.
